// File: rtl/jtag_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_mem_arbiter_if : system, debug and memory buses of the arbiter     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface jtag_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  sys_req;
  logic                  sys_we;
  logic [ADDR_W-1:0]     sys_addr;
  logic [DATA_W-1:0]     sys_wdata;
  logic [DATA_W/8-1:0]   sys_be;
  logic                  sys_gnt;
  logic                  sys_rvalid;
  logic [DATA_W-1:0]     sys_rdata;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_lock;
  logic                  dbg_gnt;
  logic                  dbg_rvalid;
  logic [DATA_W-1:0]     dbg_rdata;

  logic                  mem_en;
  logic [DATA_W/8-1:0]   mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  sys_req, sys_we, sys_addr, sys_wdata, sys_be,
    output sys_gnt, sys_rvalid, sys_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output sys_req, sys_we, sys_addr, sys_wdata, sys_be,
    input  sys_gnt, sys_rvalid, sys_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/jtag_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_mem_arbiter : shares one memory port between system and JTAG debug |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module jtag_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int RD_LAT      = 1,
  parameter int MAX_DBG_RUN = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  jtag_mem_arbiter_if.slave  bus
);

  localparam int         BE_W      = DATA_W / 8;
  localparam logic [7:0] C_MAX_RUN = 8'(MAX_DBG_RUN);

  logic              w_sys_gnt;
  logic              w_dbg_gnt;
  logic              w_rd_issue;
  logic [7:0]        r_run;

  logic              r_mem_en;
  logic [BE_W-1:0]   r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [RD_LAT-1:0] r_pipe_v;
  logic [RD_LAT-1:0] r_pipe_dbg;
  logic              r_sys_rvalid;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_sys_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  // Debug wins contention until it has taken MAX_DBG_RUN grants in a row.
  always_comb begin
    w_sys_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!RESET) begin
      if (bus.dbg_lock) begin
        w_dbg_gnt = bus.dbg_req;
      end else if (bus.sys_req && bus.dbg_req) begin
        if (r_run == C_MAX_RUN) w_sys_gnt = 1'b1;
        else                    w_dbg_gnt = 1'b1;
      end else begin
        w_sys_gnt = bus.sys_req;
        w_dbg_gnt = bus.dbg_req;
      end
    end
  end

  assign w_rd_issue = (w_sys_gnt && !bus.sys_we) || (w_dbg_gnt && !bus.dbg_we);

  always_ff @(posedge CLK) begin
    if (RESET || bus.dbg_lock || !bus.sys_req || w_sys_gnt) begin
      r_run <= '0;
    end else if (w_dbg_gnt && (r_run != C_MAX_RUN)) begin
      r_run <= r_run + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_sys_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= bus.sys_we ? bus.sys_be : '0;
      r_mem_addr  <= bus.sys_addr;
      r_mem_wdata <= bus.sys_wdata;
    end else if (w_dbg_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= bus.dbg_we ? '1 : '0;
      r_mem_addr  <= bus.dbg_addr;
      r_mem_wdata <= bus.dbg_wdata;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
    end
  end

  // Each read carries its owner through a RD_LAT-deep shift line so returns
  // from interleaved requesters are steered in issue order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pipe_v     <= '0;
      r_pipe_dbg   <= '0;
      r_sys_rvalid <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_sys_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_pipe_v[0]   <= w_rd_issue;
      r_pipe_dbg[0] <= w_dbg_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_dbg[i] <= r_pipe_dbg[i-1];
      end
      r_sys_rvalid <= r_pipe_v[RD_LAT-1] && !r_pipe_dbg[RD_LAT-1];
      r_dbg_rvalid <= r_pipe_v[RD_LAT-1] &&  r_pipe_dbg[RD_LAT-1];
      if (r_pipe_v[RD_LAT-1] && !r_pipe_dbg[RD_LAT-1]) r_sys_rdata <= bus.mem_rdata;
      if (r_pipe_v[RD_LAT-1] &&  r_pipe_dbg[RD_LAT-1]) r_dbg_rdata <= bus.mem_rdata;
    end
  end

  assign bus.sys_gnt    = w_sys_gnt;
  assign bus.dbg_gnt    = w_dbg_gnt;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.sys_rvalid = r_sys_rvalid;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.sys_rdata  = r_sys_rdata;
  assign bus.dbg_rdata  = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_jtag_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_mem_arbiter : scoreboard bench with memory and arbitration model|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_jtag_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int RD_LAT  = 3;
  localparam int MAX_RUN = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  jtag_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  jtag_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_DBG_RUN(MAX_RUN)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] dflt(input logic [31:0] w);
    return {w ^ 32'hA5A5_5A5A, w * 32'h9E37_79B9};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Physical memory behind the port, and the bench's reference memory.
  logic [63:0] pmem [logic [31:0]];
  logic [63:0] rmem [logic [31:0]];

  function automatic logic [63:0] pread(input logic [31:0] w);
    return pmem.exists(w) ? pmem[w] : dflt(w);
  endfunction
  function automatic logic [63:0] rread(input logic [31:0] w);
    return rmem.exists(w) ? rmem[w] : dflt(w);
  endfunction

  initial begin
    logic [63:0] dl [$];
    logic [63:0] v;
    logic [31:0] w;
    bus.mem_rdata = '0;
    forever begin
      @(posedge CLK); #1;
      v = {$urandom, $urandom};
      if (bus.mem_en) begin
        w = bus.mem_addr >> 3;
        if (bus.mem_we != 8'h00) pmem[w] = merge(pread(w), bus.mem_wdata, bus.mem_we);
        else                     v = pread(w);
      end
      dl.push_back(v);
      if (dl.size() >= RD_LAT) bus.mem_rdata = dl.pop_front();
    end
  end

  typedef struct { bit dbg; logic [63:0] data; int due; } rd_t;
  rd_t rdq [$];

  // Monitor: checks registered outputs, then grants, then advances the model.
  initial begin
    bit          rst_q = 1'b1;
    bit          cmd_v = 1'b0;
    logic [7:0]  cmd_we = '0;
    logic [31:0] cmd_addr = '0, last_addr = '0, w;
    logic [63:0] cmd_wdata = '0, last_wdata = '0, last_sys = '0, last_dbg = '0;
    int          run_m = 0;
    bit          egs, egd;
    rd_t         e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (rst_q) begin
        chk("rst_mem_cmd", {63'd0, bus.mem_en} | 64'(bus.mem_we) | 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst_rvalid", 64'({bus.sys_rvalid, bus.dbg_rvalid}), 64'd0);
        chk("rst_rdata", bus.sys_rdata | bus.dbg_rdata, 64'd0);
      end else begin
        if (cmd_v) begin
          chk("mem_en", 64'(bus.mem_en), 64'd1);
          chk("mem_we", 64'(bus.mem_we), 64'(cmd_we));
          chk("mem_addr", 64'(bus.mem_addr), 64'(cmd_addr));
          chk("mem_wdata", bus.mem_wdata, cmd_wdata);
          last_addr  = cmd_addr;
          last_wdata = cmd_wdata;
        end else begin
          chk("mem_idle", 64'({bus.mem_en, bus.mem_we}), 64'd0);
          chk("mem_hold", {bus.mem_addr ^ last_addr, 32'd0} | (bus.mem_wdata ^ last_wdata), 64'd0);
        end
        chk("rvalid_onehot", 64'(bus.sys_rvalid && bus.dbg_rvalid), 64'd0);
        if (bus.sys_rvalid || bus.dbg_rvalid) begin
          if (rdq.size() == 0) begin
            chk("rvalid_spurious", 64'({bus.sys_rvalid, bus.dbg_rvalid}), 64'd0);
          end else begin
            e = rdq.pop_front();
            chk("rd_owner", 64'(bus.dbg_rvalid), 64'(e.dbg));
            chk("rd_cycle", 64'(cyc), 64'(e.due));
            chk("rd_data", bus.dbg_rvalid ? bus.dbg_rdata : bus.sys_rdata, e.data);
            if (e.dbg) last_dbg = e.data;
            else       last_sys = e.data;
          end
        end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
          chk("rd_missing", 64'd0, 64'd1);
          void'(rdq.pop_front());
        end
        if (!bus.sys_rvalid) chk("sys_rdata_hold", bus.sys_rdata, last_sys);
        if (!bus.dbg_rvalid) chk("dbg_rdata_hold", bus.dbg_rdata, last_dbg);
      end

      egs = 1'b0;
      egd = 1'b0;
      if (!RESET) begin
        if (bus.dbg_lock)                    egd = bus.dbg_req;
        else if (bus.sys_req && bus.dbg_req) begin
          if (run_m >= MAX_RUN) egs = 1'b1;
          else                  egd = 1'b1;
        end else begin
          egs = bus.sys_req;
          egd = bus.dbg_req;
        end
      end
      chk("sys_gnt", 64'(bus.sys_gnt), 64'(egs));
      chk("dbg_gnt", 64'(bus.dbg_gnt), 64'(egd));

      if (RESET) begin
        rdq.delete();
        cmd_v = 1'b0;
        last_addr = '0; last_wdata = '0; last_sys = '0; last_dbg = '0;
        run_m = 0;
      end else begin
        cmd_v = egs || egd;
        if (egs) begin
          cmd_addr  = bus.sys_addr;
          cmd_wdata = bus.sys_wdata;
          cmd_we    = bus.sys_we ? bus.sys_be : 8'h00;
        end else if (egd) begin
          cmd_addr  = bus.dbg_addr;
          cmd_wdata = bus.dbg_wdata;
          cmd_we    = bus.dbg_we ? 8'hFF : 8'h00;
        end
        if (cmd_v) begin
          w = cmd_addr >> 3;
          if (cmd_we != 8'h00) rmem[w] = merge(rread(w), cmd_wdata, cmd_we);
          else if ((egs && !bus.sys_we) || (egd && !bus.dbg_we))
            rdq.push_back('{dbg: egd, data: rread(w), due: cyc + 1 + RD_LAT});
        end
        if (bus.dbg_lock || !bus.sys_req || egs) run_m = 0;
        else if (egd && run_m < MAX_RUN)         run_m++;
      end
      rst_q = RESET;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic drive(input bit sr, input bit sw, input logic [31:0] sa, input logic [63:0] sd,
                       input logic [7:0] sb, input bit dr, input bit dw, input logic [31:0] da,
                       input logic [63:0] dd, input bit lk);
    bus.sys_req = sr; bus.sys_we = sw; bus.sys_addr = sa; bus.sys_wdata = sd; bus.sys_be = sb;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd; bus.dbg_lock = lk;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  function automatic logic [31:0] raddr();
    return {25'd0, 4'($urandom_range(0, 15)), 3'b000};
  endfunction

  initial begin
    bit dr;
    idle();
    pmem[32'h20] = 64'hDEAD_BEEF_CAFE_F00D;
    rmem[32'h20] = 64'hDEAD_BEEF_CAFE_F00D;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;

    // single system read of 0x100
    drive(1, 0, 32'h100, '0, 8'hFF, 0, 0, '0, '0, 0);
    tick(); idle();
    repeat (6) tick();

    // reset arriving right behind an accepted read
    drive(1, 0, 32'h40, '0, 8'hFF, 0, 0, '0, '0, 0);
    tick(); idle(); RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    repeat (6) tick();

    // sustained contention
    drive(1, 0, raddr(), '0, 8'hFF, 1, 0, raddr(), '0, 0);
    for (int i = 0; i < 27; i++) begin
      #1;
      chk("contention_pattern", 64'({bus.sys_gnt, bus.dbg_gnt}), (i % 9 == 8) ? 64'd2 : 64'd1);
      tick();
      bus.sys_addr = raddr();
      bus.dbg_addr = raddr();
    end
    idle(); repeat (6) tick();

    // debug lock holds the system off
    for (int i = 0; i < 20; i++) begin
      dr = 1'($urandom);
      drive(1, 0, raddr(), '0, 8'hFF, dr, 0, raddr(), '0, 1);
      #1;
      chk("lock_sys_gnt", 64'(bus.sys_gnt), 64'd0);
      chk("lock_dbg_gnt", 64'(bus.dbg_gnt), 64'(dr));
      tick();
    end
    drive(1, 0, raddr(), '0, 8'hFF, 0, 0, '0, '0, 0);
    #1;
    chk("lock_release", 64'(bus.sys_gnt), 64'd1);
    tick(); idle(); repeat (6) tick();

    // interleaved owners in the read pipeline
    drive(1, 0, 32'h08, '0, 8'hFF, 0, 0, '0, '0, 0); tick();
    drive(0, 0, '0, '0, '0, 1, 0, 32'h10, '0, 0);    tick();
    drive(1, 0, 32'h18, '0, 8'hFF, 0, 0, '0, '0, 0); tick();
    idle(); repeat (8) tick();

    // partial system write, full debug write, then read both back
    drive(1, 1, 32'h80, 64'h1111_2222_3333_4444, 8'h0F, 0, 0, '0, '0, 0); tick();
    drive(0, 0, '0, '0, '0, 1, 1, 32'h88, 64'h5555_6666_7777_8888, 0);    tick();
    drive(1, 0, 32'h80, '0, 8'hFF, 0, 0, '0, '0, 0); tick();
    drive(0, 0, '0, '0, '0, 1, 0, 32'h88, '0, 0);    tick();
    idle(); repeat (8) tick();

    // randomized traffic with occasional lock and reset
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), raddr(), {$urandom, $urandom}, 8'($urandom),
            1'($urandom), 1'($urandom), raddr(), {$urandom, $urandom}, ($urandom % 8) == 0);
      RESET = (($urandom % 97) == 0);
      tick();
    end
    RESET = 1'b0;
    idle(); repeat (10) tick();
    chk("queue_drained", 64'(rdq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
